// File: rtl/clock_div_gen.sv
// Programmable clock divider. Generates a registered divided clock, a period-start tick
// and a divisor-change acknowledge. New divisors are applied only at period boundaries.
module clock_div_gen #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clkDiv,
  output logic             tick,
  output logic             div_ack,
  output logic             err
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(DEFAULT_DIV - 1);

  if (CNT_W < 2 || CNT_W > 32) begin : g_chk_cnt_w
    $error("clock_div_gen: CNT_W must be in 2..32");
  end

  if (DEFAULT_DIV < 2 ||
      longint'(DEFAULT_DIV) > ((longint'(1) << CNT_W) - 1)) begin : g_chk_default_div
    $error("clock_div_gen: DEFAULT_DIV must be in 2..2^CNT_W-1");
  end

  function automatic logic [CNT_W-1:0] half_of(input logic [CNT_W-1:0] n);
    return n >> 1;
  endfunction

  function automatic logic legal_div(input logic [CNT_W-1:0] n);
    return n >= TWO;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_cur;
  logic [CNT_W-1:0] div_pend;
  logic             pend_vld;

  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] div_cur_nxt;
  logic [CNT_W-1:0] div_pend_nxt;
  logic             pend_vld_nxt;
  logic             clk_div_nxt;
  logic             tick_nxt;
  logic             ack_nxt;
  logic             err_nxt;
  logic             wrap;
  logic             load_ok;

  always_comb begin
    cnt_nxt      = cnt;
    div_cur_nxt  = div_cur;
    div_pend_nxt = div_pend;
    pend_vld_nxt = pend_vld;
    clk_div_nxt  = 1'b0;
    tick_nxt     = 1'b0;
    ack_nxt      = 1'b0;
    load_ok      = div_load && legal_div(div_val);
    err_nxt      = err | (div_load & ~legal_div(div_val));
    // >= rather than == keeps the counter safe should it ever sit past the end
    wrap         = (cnt >= div_cur - ONE);

    if (!en) begin
      // Idle: a pending divisor can be swapped in at once since no clock is being produced
      if (pend_vld) begin
        div_cur_nxt  = div_pend;
        pend_vld_nxt = 1'b0;
        ack_nxt      = 1'b1;
      end
      cnt_nxt = div_cur_nxt - ONE;
    end else if (wrap) begin
      if (pend_vld) begin
        div_cur_nxt  = div_pend;
        pend_vld_nxt = 1'b0;
        ack_nxt      = 1'b1;
      end
      cnt_nxt     = '0;
      clk_div_nxt = 1'b1;
      tick_nxt    = 1'b1;
    end else begin
      cnt_nxt     = cnt + ONE;
      clk_div_nxt = (cnt_nxt < half_of(div_cur));
    end

    // A load arriving on a wrap edge is queued for the following wrap
    if (load_ok) begin
      div_pend_nxt = div_val;
      pend_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= CNT_RST;
      div_cur  <= DIV_RST;
      div_pend <= '0;
      pend_vld <= 1'b0;
      clkDiv   <= 1'b0;
      tick     <= 1'b0;
      div_ack  <= 1'b0;
      err      <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      div_cur  <= div_cur_nxt;
      div_pend <= div_pend_nxt;
      pend_vld <= pend_vld_nxt;
      clkDiv   <= clk_div_nxt;
      tick     <= tick_nxt;
      div_ack  <= ack_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_clock_div_gen.sv
// Bench for clock_div_gen: directed vector table, hand-written corner sequences and
// randomized traffic checked against a period-queue reference model.
module tb_clock_div_gen;

  localparam int CNT_W       = 16;
  localparam int DEFAULT_DIV = 4;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b1;
  logic             en       = 1'b0;
  logic             div_load = 1'b0;
  logic [CNT_W-1:0] div_val  = '0;
  logic             clkDiv;
  logic             tick;
  logic             div_ack;
  logic             err;

  int n_vec = 0;
  int n_bad = 0;

  clock_div_gen #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .div_val (div_val),
    .div_load(div_load),
    .clkDiv  (clkDiv),
    .tick    (tick),
    .div_ack (div_ack),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Reference model: each started period is expanded into a queue of {tick, clk} samples.
  bit [1:0] exp_q[$];
  int       m_n;
  int       m_pend;
  bit       m_clk, m_tick, m_ack, m_err;

  task automatic model_reset();
    exp_q.delete();
    m_n    = DEFAULT_DIV;
    m_pend = 0;
    m_clk  = 1'b0;
    m_tick = 1'b0;
    m_ack  = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit l, input int v);
    m_ack = 1'b0;
    if (l && v < 2) m_err = 1'b1;
    if (!e) begin
      exp_q.delete();
      if (m_pend != 0) begin
        m_n    = m_pend;
        m_pend = 0;
        m_ack  = 1'b1;
      end
      m_clk  = 1'b0;
      m_tick = 1'b0;
    end else begin
      if (exp_q.size() == 0) begin
        if (m_pend != 0) begin
          m_n    = m_pend;
          m_pend = 0;
          m_ack  = 1'b1;
        end
        for (int k = 0; k < m_n; k++) exp_q.push_back({k == 0, k < m_n / 2});
      end
      {m_tick, m_clk} = exp_q.pop_front();
    end
    if (l && v >= 2) m_pend = v;
  endtask

  task automatic check(input string name, input bit ec, input bit et, input bit ea, input bit ee);
    n_vec++;
    if (clkDiv !== ec || tick !== et || div_ack !== ea || err !== ee) begin
      n_bad++;
      $display("FAIL %s: got clkDiv=%b tick=%b div_ack=%b err=%b, expected clkDiv=%b tick=%b div_ack=%b err=%b",
               name, clkDiv, tick, div_ack, err, ec, et, ea, ee);
    end
  endtask

  task automatic step(input bit e, input bit l, input int v);
    en       = e;
    div_load = l;
    div_val  = CNT_W'(v);
    @(posedge clk);
    model_edge(e, l, v);
    #1;
  endtask

  task automatic sc(input string name, input bit e, input bit l, input int v,
                    input bit ec, input bit et, input bit ea, input bit ee);
    step(e, l, v);
    check(name, ec, et, ea, ee);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_val  = '0;
    model_reset();
    #1;
    check("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit e;
    bit l;
    int v;
    bit ec;
    bit et;
    bit ea;
    bit ee;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit e, input bit l, input int v,
                     input bit ec, input bit et, input bit ea, input bit ee);
    vec_t r;
    r.e = e; r.l = l; r.v = v; r.ec = ec; r.et = et; r.ea = ea; r.ee = ee;
    tbl.push_back(r);
  endtask

  initial begin
    // N=4 free-running, then a load of 3 at cnt=1 taking effect at the next wrap
    add(1, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 3, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0);

    #2;
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].e, tbl[i].l, tbl[i].v);
      check($sformatf("vec%0d", i), tbl[i].ec, tbl[i].et, tbl[i].ea, tbl[i].ee);
    end

    // Back-to-back loads 5 then 7: one ack, next period 7 cycles (3 high, 4 low)
    do_reset();
    sc("dbl_c1",  1, 0, 0, 1, 1, 0, 0);
    sc("dbl_c2",  1, 1, 5, 1, 0, 0, 0);
    sc("dbl_c3",  1, 1, 7, 0, 0, 0, 0);
    sc("dbl_c4",  1, 0, 0, 0, 0, 0, 0);
    sc("dbl_c5",  1, 0, 0, 1, 1, 1, 0);
    sc("dbl_c6",  1, 0, 0, 1, 0, 0, 0);
    sc("dbl_c7",  1, 0, 0, 1, 0, 0, 0);
    sc("dbl_c8",  1, 0, 0, 0, 0, 0, 0);
    sc("dbl_c9",  1, 0, 0, 0, 0, 0, 0);
    sc("dbl_c10", 1, 0, 0, 0, 0, 0, 0);
    sc("dbl_c11", 1, 0, 0, 0, 0, 0, 0);
    sc("dbl_c12", 1, 0, 0, 1, 1, 0, 0);

    // Illegal divisors 1 and 0: sticky err, period unchanged, cleared by reset
    do_reset();
    sc("err_c1", 1, 0, 0, 1, 1, 0, 0);
    sc("err_c2", 1, 1, 1, 1, 0, 0, 1);
    sc("err_c3", 1, 1, 0, 0, 0, 0, 1);
    sc("err_c4", 1, 0, 0, 0, 0, 0, 1);
    sc("err_c5", 1, 0, 0, 1, 1, 0, 1);
    sc("err_c6", 1, 0, 0, 1, 0, 0, 1);
    do_reset();
    sc("err_clr", 1, 0, 0, 1, 1, 0, 0);

    // en dropped at cnt=0, then re-raised
    do_reset();
    sc("en_c1", 1, 0, 0, 1, 1, 0, 0);
    sc("en_c2", 1, 0, 0, 1, 0, 0, 0);
    sc("en_c3", 1, 0, 0, 0, 0, 0, 0);
    sc("en_c4", 1, 0, 0, 0, 0, 0, 0);
    sc("en_c5", 1, 0, 0, 1, 1, 0, 0);
    sc("en_off1", 0, 0, 0, 0, 0, 0, 0);
    sc("en_off2", 0, 0, 0, 0, 0, 0, 0);
    sc("en_on1", 1, 0, 0, 1, 1, 0, 0);
    sc("en_on2", 1, 0, 0, 1, 0, 0, 0);
    sc("en_on3", 1, 0, 0, 0, 0, 0, 0);

    // Pending divisor applied immediately while disabled
    do_reset();
    sc("idle_c1", 1, 1, 3, 1, 1, 0, 0);
    sc("idle_c2", 0, 0, 0, 0, 0, 1, 0);
    sc("idle_c3", 1, 0, 0, 1, 1, 0, 0);
    sc("idle_c4", 1, 0, 0, 0, 0, 0, 0);
    sc("idle_c5", 1, 0, 0, 0, 0, 0, 0);
    sc("idle_c6", 1, 0, 0, 1, 1, 0, 0);

    // Asynchronous reset mid-period with a pending load discards it
    do_reset();
    sc("rst_c1", 1, 0, 0, 1, 1, 0, 0);
    sc("rst_c2", 1, 1, 6, 1, 0, 0, 0);
    #2;
    do_reset();
    sc("rst_p1", 1, 0, 0, 1, 1, 0, 0);
    sc("rst_p2", 1, 0, 0, 1, 0, 0, 0);
    sc("rst_p3", 1, 0, 0, 0, 0, 0, 0);
    sc("rst_p4", 1, 0, 0, 0, 0, 0, 0);
    sc("rst_p5", 1, 0, 0, 1, 1, 0, 0);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit e, l;
      int v;
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 7) == 0);
      v = $urandom_range(0, 12);
      step(e, l, v);
      check($sformatf("rand%0d", i), m_clk, m_tick, m_ack, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
